// File: rtl/conv_pkg.sv
// conv_pkg: shared geometry defaults and FSM state encoding for the conv window feeder.
package conv_pkg;
  localparam int DW    = 8;
  localparam int K     = 3;
  localparam int IMG_W = 30;
  localparam int IMG_H = 30;
  localparam int CW    = 5;
  localparam int OUT_W = IMG_W - K + 1;
  localparam int OUT_H = IMG_H - K + 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
endpackage

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: one-row delay line; q is the pixel written DEPTH enables ago.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int DEPTH = IMG_W,
  parameter int W     = DW
) (
  input  logic         clk,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [DEPTH-1:0][W-1:0] mem_q;
  always_ff @(posedge clk) begin
    if (en) mem_q <= {mem_q[DEPTH-2:0], d};
  end
  assign q = mem_q[DEPTH-1];
endmodule

// File: rtl/conv_window_feeder.sv
// conv_window_feeder: raster pixel stream in, one KxK window per output position out.
// Optional stall counter port enabled by defining CONV_FEED_STALL_CNT_EN.
module conv_window_feeder
  import conv_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DW-1:0]       s_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [K*K*DW-1:0]   m_window,
  output logic [CW-1:0]       m_i,
  output logic [CW-1:0]       m_j,
  output logic                m_last,
  output logic                busy,
  output logic                done
`ifdef CONV_FEED_STALL_CNT_EN
  ,output logic [15:0]        stall_cycles
`endif
);
  state_e state_q, state_d;
  logic [CW-1:0] r_q, r_d, c_q, c_d;
  logic acc, go, last_col, last_pix, win_ok;
  logic [K-1:0][DW-1:0] tap;
  logic [K-1:0][K-1:0][DW-1:0] win_q, win_d;
  logic m_valid_q, m_last_q;
  logic [K*K*DW-1:0] m_window_q;
  logic [CW-1:0] m_i_q, m_j_q;

  assign s_ready = (state_q == RUN) && (!m_valid_q || m_ready);
  assign acc     = s_valid && s_ready;
  assign go      = (state_q == IDLE) && start;
  assign busy    = (state_q == RUN) || (state_q == DRAIN);
  assign done    = state_q == DONE;

  always_comb begin
    last_col = c_q == CW'(IMG_W-1);
    last_pix = last_col && (r_q == CW'(IMG_H-1));
    win_ok   = (r_q >= CW'(K-1)) && (c_q >= CW'(K-1));
    c_d = go ? '0 : acc ? (last_col ? '0 : c_q + 1'b1) : c_q;
    r_d = go ? '0 : (acc && last_col) ? (last_pix ? '0 : r_q + 1'b1) : r_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? RUN : IDLE;
      RUN:     state_d = (acc && last_pix) ? DRAIN : RUN;
      DRAIN:   state_d = (m_valid_q && m_ready && m_last_q) ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
    end
  end

  // Row taps: tap[K-1] is the live row, tap[0] the oldest buffered row.
  assign tap[K-1] = s_data;
  for (genvar g = 0; g < K-1; g++) begin : g_lb
    conv_line_buffer #(.DEPTH(IMG_W), .W(DW)) u_lb (
      .clk (clk),
      .en  (acc),
      .d   (tap[g+1]),
      .q   (tap[g])
    );
  end

  always_comb begin
    for (int y = 0; y < K; y++) win_d[y] = {tap[y], win_q[y][K-1:1]};
  end

  always_ff @(posedge clk) begin
    if (acc) win_q <= win_d;
  end

  // The output stage captures the shifted window directly so it appears one cycle after its last pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      m_window_q <= '0;
      m_i_q      <= '0;
      m_j_q      <= '0;
    end else if (acc && win_ok) begin
      m_valid_q  <= 1'b1;
      m_last_q   <= last_pix;
      m_window_q <= win_d;
      m_i_q      <= r_q - CW'(K-1);
      m_j_q      <= c_q - CW'(K-1);
    end else if (m_ready) begin
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
    end
  end

  assign m_valid  = m_valid_q;
  assign m_last   = m_last_q;
  assign m_window = m_window_q;
  assign m_i      = m_i_q;
  assign m_j      = m_j_q;

`ifdef CONV_FEED_STALL_CNT_EN
  logic [15:0] stall_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else if (go) stall_q <= '0;
    else if (m_valid_q && !m_ready && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end
  assign stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_conv_window_feeder.sv
// tb_conv_window_feeder: frame-level scenarios from a table, scoreboard of expected windows.
module tb_conv_window_feeder;
  logic clk = 1'b0;
  logic rst_n, start, s_valid, s_ready, m_valid, m_ready, m_last, busy, done;
  logic [7:0] s_data;
  logic [71:0] m_window;
  logic [4:0] m_i, m_j;
`ifdef CONV_FEED_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conv_window_feeder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_window     (m_window),
    .m_i          (m_i),
    .m_j          (m_j),
    .m_last       (m_last),
    .busy         (busy),
    .done         (done)
`ifdef CONV_FEED_STALL_CNT_EN
    ,.stall_cycles (stall_cycles)
`endif
  );

  typedef struct {
    int ready_pct;
    int gap;
    int start_at;
    int rst_at;
    int stall_at;
    int exp_win;
  } vec_t;

  typedef struct packed {
    logic [71:0] w;
    logic [4:0]  i;
    logic [4:0]  j;
    logic        last;
  } exp_t;

  exp_t sb[$];
  vec_t tv[6];
  logic [71:0] first_exp;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int r, input int c);
    return 8'((r * 30 + c) & 255);
  endfunction

  task automatic chk_reset();
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_m_i", m_i, 0);
    chk("rst_m_j", m_j, 0);
    chk("rst_m_window", m_window, 0);
  endtask

  task automatic run_frame(input vec_t v);
    int pr = 0, pc = 0, pidx = 0, wins = 0, stall_seen = 0, stall_left = 0;
    bit fin = 0, stalled_once = 0;
    exp_t e, a;
    sb.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1 chk("busy_after_start", busy, 1);
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      if (v.rst_at >= 0 && pidx == v.rst_at) begin
        s_valid = 1'b0;
        rst_n = 1'b0;
        #1 chk_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        return;
      end
      start   = v.start_at >= 0 && pidx == v.start_at;
      s_valid = pidx < 900 && (v.gap == 0 || cyc % 3 != 0);
      s_data  = pix(pr, pc);
      if (stall_left > 0) begin
        m_ready = 1'b0;
        stall_left--;
      end else if (v.stall_at >= 0 && !stalled_once && pidx >= v.stall_at && m_valid) begin
        stalled_once = 1;
        stall_left = 9;
        m_ready = 1'b0;
      end else begin
        m_ready = $urandom_range(99) < v.ready_pct;
      end
      #1;
      if (m_valid && !m_ready) begin
        stall_seen++;
        chk("s_ready_backpressure", s_ready, 0);
      end
      if (m_valid && m_ready) begin
        wins++;
        a = {m_window, m_i, m_j, m_last};
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_window: got %h expected none", a);
        end else begin
          e = sb.pop_front();
          chk("window", a, e);
        end
        if (wins == 1) chk("first_window", m_window, first_exp);
      end
      if (s_valid && s_ready) begin
        if (pr >= 2 && pc >= 2) begin
          for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++)
              e.w[(ky*3+kx)*8 +: 8] = pix(pr - 2 + ky, pc - 2 + kx);
          e.i = 5'(pr - 2);
          e.j = 5'(pc - 2);
          e.last = pr == 29 && pc == 29;
          sb.push_back(e);
        end
        pc = pc == 29 ? 0 : pc + 1;
        if (pc == 0) pr++;
        pidx++;
      end
      if (done) begin
        fin = 1;
        break;
      end
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: got no done expected done");
    end
    chk("window_count", wins, v.exp_win);
    chk("scoreboard_empty", sb.size(), 0);
    chk("busy_at_done", busy, 0);
`ifdef CONV_FEED_STALL_CNT_EN
    chk("stall_cycles", stall_cycles, stall_seen);
    if (v.stall_at >= 0) chk("stall_cycles_10", stall_cycles, 10);
`endif
    @(negedge clk);
    #1 chk("done_single_pulse", done, 0);
    chk("busy_after_done", busy, 0);
  endtask

  initial begin
    tv[0] = '{100, 0, -1, -1, -1, 784};
    tv[1] = '{50,  0, -1, -1, -1, 784};
    tv[2] = '{100, 1, -1, -1, -1, 784};
    tv[3] = '{100, 0, 400, -1, -1, 784};
    tv[4] = '{70,  0, -1, 500, -1, 784};
    tv[5] = '{100, 0, -1, -1, 100, 784};
    first_exp = {8'd62, 8'd61, 8'd60, 8'd32, 8'd31, 8'd30, 8'd2, 8'd1, 8'd0};
    rst_n = 1'b0;
    start = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    m_ready = 1'b0;
    #1 chk_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 6; t++) run_frame(tv[t]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
